// File: rtl/run_ctrl_pkg.sv
// Shared types for the core run controller: FSM encoding and stop causes.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_NONE  = 2'b00;
    localparam cause_t CAUSE_LIMIT = 2'b01;
    localparam cause_t CAUSE_HALT  = 2'b10;
    localparam cause_t CAUSE_ABORT = 2'b11;

endpackage

// File: rtl/cpu_run_ctrl_rise_detect.sv
// Registered rising-edge detector for a level input.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Core run controller: sequences core reset, gates execution via clock
// enable, counts enabled cycles and stops on limit, halt or abort.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_W    = 16,
    parameter int MAX_CYCLES = 250,
    parameter int RST_HOLD   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               halt_in,
    input  logic               step_mode,
    input  logic               step_req,
    output logic               cpu_rst_n,
    output logic               cpu_en,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_cause,
    output logic [CYCLE_W-1:0] cycle_cnt
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [CYCLE_W-1:0] LAST_CNT = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] CNT_SAT = '1;
    localparam bit LIMITED = (MAX_CYCLES != 0);

    state_e              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                cpu_rst_n_q;
    logic                cpu_en_q;
    logic                busy_q;
    logic                done_q;
    cause_t              cause_q;
    logic [CYCLE_W-1:0]  cnt_q;

    logic [CYCLE_W-1:0]  cnt_d;
    logic                step_rise;
    logic                limit_hit;

    rise_detect u_step_rise (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (step_req),
        .rise_o (step_rise)
    );

    // Saturation only matters when the run is unlimited.
    assign cnt_d = (cpu_en_q && cnt_q != CNT_SAT)
                 ? cnt_q + CYCLE_W'(1) : cnt_q;
    assign limit_hit = LIMITED && cpu_en_q && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RESET;
                        hold_q      <= HOLD_W'(RST_HOLD);
                        cnt_q       <= '0;
                        cause_q     <= CAUSE_NONE;
                        cpu_rst_n_q <= 1'b0;
                        cpu_en_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (abort) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cause_q <= CAUSE_ABORT;
                    end else if (hold_q == HOLD_W'(1)) begin
                        state_q     <= ST_RUN;
                        cpu_rst_n_q <= 1'b1;
                        cpu_en_q    <= ~step_mode;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    if (abort || halt_in || limit_hit) begin
                        state_q  <= ST_DONE;
                        cpu_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        if (abort) begin
                            cause_q <= CAUSE_ABORT;
                        end else if (halt_in) begin
                            cause_q <= CAUSE_HALT;
                        end else begin
                            cause_q <= CAUSE_LIMIT;
                        end
                    end else begin
                        cpu_en_q <= step_mode ? step_rise : 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign cpu_en     = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller that sits between the board/top-level clock domain and the processor core, replacing the fixed simulation-only 250-cycle clock loop. It sequences the core's reset, gates execution through a clock enable, counts executed cycles, and stops the core on a cycle limit, a core halt, or an external abort. It also offers a single-step mode for bring-up. One instance drives one core; the same block serves both simulation and the FPGA build.

## Interface
- `CYCLE_W`, 16: width of the cycle counter.
- `MAX_CYCLES`, 250: enabled-cycle limit. 0 means unlimited. Must fit in `CYCLE_W`.
- `RST_HOLD`, 4: number of cycles `cpu_rst_n` is held low after start. Must be at least 1.

Ports:
- `clk`  in  1  single system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch a run; honoured only in IDLE or DONE.
- `abort`  in  1  stop the run immediately.
- `halt_in`  in  1  halt indication from the core.
- `step_mode`  in  1  1 = single-step, 0 = free-run.
- `step_req`  in  1  level input; each rising edge requests one step.
- `cpu_rst_n`  out  1  active-low reset to the core.
- `cpu_en`  out  1  core clock enable.
- `busy`  out  1  high in RESET or RUN.
- `done`  out  1  high in DONE.
- `done_cause`  out  2  stop reason: 00 none, 01 limit, 10 halt, 11 abort.
- `cycle_cnt`  out  CYCLE_W  count of cycles with `cpu_en` = 1 in the current run.

## Operation
- FSM states: IDLE, RESET, RUN, DONE. The state is encoded in the package.
- **IDLE**
  - `start` goes to RESET.
  - On entering RESET: `cycle_cnt` := 0, `done_cause` := 00, and the hold counter is loaded with `RST_HOLD`.
- **RESET**
  - `cpu_rst_n` = 0 and `cpu_en` = 0.
  - After `RST_HOLD` cycles: go to RUN with `cpu_rst_n` := 1.
- **RUN, free-run** (`step_mode` = 0)
  - `cpu_en` = 1 on every cycle.
- **RUN, step mode** (`step_mode` = 1)
  - `cpu_en` = 1 for exactly one cycle per detected rising edge of `step_req`; otherwise 0.
  - Rising edge is detected as `step_req` & ~`step_req_q`.
- **Cycle counting**
  - `cycle_cnt` increments on every edge where `cpu_en` = 1.
  - With `MAX_CYCLES` = 0, `cycle_cnt` saturates at all-ones.
- **Exit from RUN**, evaluated on every edge. Priority order: abort > halt > limit.
  - `abort`: cause 11.
  - `halt_in`: cause 10.
  - Limit: `cpu_en` = 1 and `cycle_cnt` = `MAX_CYCLES`−1, giving cause 01.
  - The enabled cycle on which an exit is taken is still counted.
- **DONE**
  - `cpu_en` = 0 and `done` = 1.
  - `cpu_rst_n` keeps its value, so core state stays inspectable.
  - `cycle_cnt` and `done_cause` are held.
  - `start` begins a new run (goes to RESET).
- **Abort during RESET**
  - Go to DONE with cause 11.
  - `cpu_rst_n` stays 0 and `cycle_cnt` stays 0.
- **Ignored inputs**
  - `start` while `busy` is ignored.
  - `halt_in` and `step_req` outside RUN are ignored.
- **`step_mode` changes** take effect on the next edge.
- **Outputs** are all registered; no combinational path from input to output.

## Timing
- Reset values (applied asynchronously when `reset` = 0):
  - State = IDLE.
  - `cpu_rst_n` = 0, `cpu_en` = 0, `busy` = 0, `done` = 0.
  - `done_cause` = 00, `cycle_cnt` = 0, `step_req_q` = 0.
- `start` sampled at edge T:
  - From T: `busy` = 1 and `cpu_rst_n` = 0.
  - At edge T+`RST_HOLD`: `cpu_rst_n` = 1, and `cpu_en` = 1 if in free-run.
- Free-run with no halt:
  - `cpu_en` is high for exactly `MAX_CYCLES` consecutive cycles.
  - `done` rises on the same edge that `cpu_en` falls.
- Exit latency: an exit condition sampled at edge E gives `cpu_en` = 0 and `done` = 1 after E. There are no extra enabled cycles.
- Step latency: `step_req` rising before edge E gives a `cpu_en` pulse in the cycle after E. Holding `step_req` high produces only one step.
- Reset asserted mid-run: all outputs go to reset values without waiting for a clock.

## Structure
- Package `run_ctrl_pkg`: state encoding and the `done_cause` constants (`CAUSE_NONE`, `CAUSE_LIMIT`, `CAUSE_HALT`, `CAUSE_ABORT`).
- Sub-module `rise_detect`: registered rising-edge detector with async active-low reset, used for `step_req`.
- The hold counter and `cycle_cnt` stay in the top-level block.

## Test plan
- Defaults, `step_mode` = 0, one-cycle `start` pulse:
  - `cpu_rst_n` is low for 4 cycles.
  - `cpu_en` is high for exactly 250 cycles.
  - Then `done` = 1, `done_cause` = 01, `cycle_cnt` = 250, `busy` = 0.
- Free-run, `halt_in` pulsed while `cycle_cnt` = 36:
  - `cycle_cnt` = 37, `done_cause` = 10.
  - `cpu_en` is low from the next cycle.
- Step mode, three `step_req` pulses each held 5 cycles:
  - Exactly three single-cycle `cpu_en` pulses.
  - `cycle_cnt` = 3, `done` = 0.
- `abort` during the 2nd RESET cycle:
  - `done_cause` = 11, `cpu_rst_n` stays 0, `cycle_cnt` = 0.
  - A new `start` then runs normally to cause 01.
- `abort`, `halt_in`, and the limit all on the same edge (`cycle_cnt` = 249): `done_cause` = 11 and `cycle_cnt` = 250.
- `reset` dropped at cycle 100 of a run, between clock edges:
  - All outputs reach their reset values immediately.
  - `start` is ignored until `reset` is released.
